hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit.sv | 146 ++++++++++++++
 tb/tb_hilo_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register file with multi-cycle multiply/divide sequencing.
// Optional HILO_BYPASS_EN: same-cycle write-through of mthi/mtlo and commit data.
module hilo_unit #(
    parameter int unsigned MD_LATENCY = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_mult,
    output logic        md_multu,
    output logic        md_div,
    output logic        md_divu,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [5:0] CNT_INIT = 6'(MD_LATENCY - 1);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;
    logic        divz_q;
    logic        dz_q;

    logic        start;
    logic [3:0]  op_d;
    logic        divz_d;
    logic        busy;
    logic        commit;

    assign start  = mult | multu | div | divu;
    assign busy   = (state_q == BUSY);
    assign commit = busy && (cnt_q == 6'd0);

    // op_d = {mult, multu, div, divu}, one-hot by priority
    always_comb begin
        op_d = 4'b0000;
        if (mult)       op_d = 4'b1000;
        else if (multu) op_d = 4'b0100;
        else if (div)   op_d = 4'b0010;
        else if (divu)  op_d = 4'b0001;
    end

    assign divz_d = (op_d[1] | op_d[0]) && (rt_data == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'b0000;
            divz_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            dz_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= rs_data;
                        b_q     <= rt_data;
                        op_q    <= op_d;
                        divz_q  <= divz_d;
                        cnt_q   <= CNT_INIT;
                        dz_q    <= divz_d && (CNT_INIT == 6'd0);
                        state_q <= BUSY;
                    end else begin
                        if (mthi) hi_q <= rs_data;
                        if (mtlo) lo_q <= rs_data;
                    end
                end
                BUSY: begin
                    if (cnt_q == 6'd0) begin
                        if (!divz_q) begin
                            hi_q <= md_hi;
                            lo_q <= md_lo;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                        // dz lands on the commit cycle, i.e. when cnt reaches 0
                        dz_q  <= divz_q && (cnt_q == 6'd1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall    = busy || ((state_q == IDLE) && start);
    assign dz       = dz_q;
    assign md_a     = a_q;
    assign md_b     = b_q;
    assign md_mult  = busy & op_q[3];
    assign md_multu = busy & op_q[2];
    assign md_div   = busy & op_q[1];
    assign md_divu  = busy & op_q[0];

`ifdef HILO_BYPASS_EN
    always_comb begin
        hi = hi_q;
        lo = lo_q;
        if ((state_q == IDLE) && !start) begin
            if (mthi) hi = rs_data;
            if (mtlo) lo = rs_data;
        end else if (commit && !divz_q) begin
            hi = md_hi;
            lo = md_lo;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit with a behavioural mul/div datapath.
module tb_hilo_unit;

    localparam int L = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mult = 0, multu = 0, div = 0, divu = 0;
    logic        mthi = 0, mtlo = 0;
    logic [31:0] rs_data = 0, rt_data = 0;
    logic [31:0] md_hi, md_lo;
    logic [31:0] md_a, md_b, hi, lo;
    logic        md_mult, md_multu, md_div, md_divu;
    logic        stall, dz;

    always #5 clk = ~clk;

    hilo_unit #(.MD_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .mthi(mthi), .mtlo(mtlo),
        .rs_data(rs_data), .rt_data(rt_data),
        .md_hi(md_hi), .md_lo(md_lo),
        .md_a(md_a), .md_b(md_b),
        .md_mult(md_mult), .md_multu(md_multu),
        .md_div(md_div), .md_divu(md_divu),
        .hi(hi), .lo(lo), .stall(stall), .dz(dz)
    );

    // {hi, lo} of the arithmetic for op = {mult, multu, div, divu}
    function automatic logic [63:0] md_calc(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 64'hDEADBEEF0BADF00D;
        if (op == 4'b1000) r = 64'(sa * sb);
        else if (op == 4'b0100) r = {32'd0, a} * {32'd0, b};
        else if (op == 4'b0010 && b != 0) r = {32'(sa % sb), 32'(sa / sb)};
        else if (op == 4'b0001 && b != 0) r = {a % b, a / b};
        return r;
    endfunction

    always_comb {md_hi, md_lo} = md_calc({md_mult, md_multu, md_div, md_divu}, md_a, md_b);

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          dzc;
        logic [3:0]  op;
    } op_exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        st;
        int          tag;
    } st_exp_t;

    op_exp_t     opq[$];
    st_exp_t     stq[$];
    logic [31:0] hi_m = 0, lo_m = 0;
    int          nchk = 0;
    int          nfail = 0;
    int          tagn = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operation monitor: one stall burst followed by a non-stall cycle is one op
    initial begin
        int scnt = 0, dzc = 0, selbad = 0;
        logic [3:0] sel, eop;
        op_exp_t e;
        forever begin
            @(negedge clk);
            sel = {md_mult, md_multu, md_div, md_divu};
            if (rst) begin
                scnt = 0; dzc = 0; selbad = 0;
            end else if (stall) begin
                scnt++;
                if (dz) dzc++;
                eop = (opq.size() > 0) ? opq[0].op : 4'b0000;
                if (scnt == 1 && sel != 4'b0000) selbad++;
                if (scnt >= 2 && sel != eop) selbad++;
            end else if (scnt > 0) begin
                if (dz) dzc++;
                if (opq.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL unexpected_op: stall burst %0d with no queued op", scnt);
                end else begin
                    e = opq.pop_front();
                    chk("stall_len", 32'(scnt), 32'(L + 1));
                    chk("op_hi", hi, e.hi);
                    chk("op_lo", lo, e.lo);
                    chk("dz_count", 32'(dzc), 32'(e.dzc));
                    chk("op_sel_bad_cycles", 32'(selbad), 32'd0);
                    chk("done_sel", {28'd0, sel}, 32'd0);
                end
                scnt = 0; dzc = 0; selbad = 0;
            end
        end
    end

    // State monitor: compares hi/lo/stall for every queued snapshot
    initial begin
        st_exp_t s;
        forever begin
            @(negedge clk);
            if (stq.size() > 0) begin
                s = stq.pop_front();
                if (hi !== s.hi || lo !== s.lo || stall !== s.st) begin
                    nfail++;
                    $display("FAIL state#%0d: got hi=%h lo=%h stall=%b expected hi=%h lo=%h stall=%b",
                             s.tag, hi, lo, stall, s.hi, s.lo, s.st);
                end
                nchk++;
            end
        end
    end

    task automatic snap(logic [31:0] h, logic [31:0] l, logic st);
        stq.push_back('{h, l, st, tagn});
        tagn++;
        @(negedge clk);
    endtask

    task automatic do_mt(bit h, bit l, logic [31:0] v);
        @(posedge clk); #1;
        mthi = h; mtlo = l; rs_data = v;
`ifdef HILO_BYPASS_EN
        snap(h ? v : hi_m, l ? v : lo_m, 1'b0);
`else
        snap(hi_m, lo_m, 1'b0);
`endif
        if (h) hi_m = v;
        if (l) lo_m = v;
        @(posedge clk); #1;
        mthi = 0; mtlo = 0;
        snap(hi_m, lo_m, 1'b0);
    endtask

    task automatic do_op(logic [3:0] req, bit h, bit l, logic [31:0] rs, logic [31:0] rt);
        logic [3:0] sel;
        logic [63:0] r;
        bit z;
        int n;
        if (req[3]) sel = 4'b1000;
        else if (req[2]) sel = 4'b0100;
        else if (req[1]) sel = 4'b0010;
        else sel = 4'b0001;
        z = (sel[1] | sel[0]) && (rt == 0);
        r = md_calc(sel, rs, rt);
        if (!z) {hi_m, lo_m} = r;
        @(posedge clk); #1;
        {mult, multu, div, divu} = req;
        mthi = h; mtlo = l; rs_data = rs; rt_data = rt;
        opq.push_back('{hi_m, lo_m, z ? 1 : 0, sel});
        n = 0;
        do begin
            @(posedge clk); #1;
            rs_data = $urandom; rt_data = $urandom;
            n++;
        end while (stall && n < 100);
        if (n >= 100) begin
            nchk++; nfail++;
            $display("FAIL op_timeout: stall still %b after %0d cycles", stall, n);
        end
        @(posedge clk); #1;
        {mult, multu, div, divu} = 4'b0000;
        mthi = 0; mtlo = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rq;
        logic [31:0] rt;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_md_a", md_a, 32'd0);
        chk("rst_md_b", md_b, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);

        do_mt(1, 0, 32'hCAFEF00D);
        do_op(4'b0100, 0, 0, 32'hFFFFFFFF, 32'd2);
        do_mt(1, 0, 32'h11);
        do_mt(0, 1, 32'h22);
        do_op(4'b0010, 0, 0, $urandom, 32'd0);
        snap(32'h11, 32'h22, 1'b0);
        do_op(4'b1001, 0, 1, 32'hFFFF_FFF9, 32'd3);
        do_mt(1, 1, 32'h1234_5678);
        do_op(4'b0001, 1, 0, 32'd100, 32'd0);
        do_op(4'b0010, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                rq = 4'($urandom_range(1, 15));
                rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                do_op(rq, 1'($urandom), 1'($urandom), $urandom, rt);
            end else begin
                do_mt(1'($urandom), 1'($urandom), $urandom);
            end
        end

        do_mt(1, 1, 32'hA5A5_5A5A);
        @(posedge clk); #1;
        mult = 1; rs_data = 32'd5; rt_data = 32'd7;
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0; mult = 0;
        hi_m = 0; lo_m = 0;
        snap(32'd0, 32'd0, 1'b0);
        repeat (45) @(posedge clk);
        #1;
        snap(32'd0, 32'd0, 1'b0);

        do_op(4'b1000, 0, 0, 32'hFFFF_FFFE, 32'h0000_0010);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("opq_drained", 32'(opq.size()), 32'd0);
        chk("stq_drained", 32'(stq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
